// File: rtl/dmem_port_arbiter_pkg.sv
// Shared definitions for the data-memory port arbiter: widths, FSM encoding
// and the request bundle seen from either master.
package dmem_port_arbiter_pkg;

    localparam int unsigned DBITS        = 32;
    localparam int unsigned DMEMADDRBITS = 16;
    localparam int unsigned DMEMWORDBITS = 2;
    localparam int unsigned WIDXBITS     = DMEMADDRBITS - DMEMWORDBITS;

    // Request-bundle field widths
    localparam int unsigned REQ_WE_BITS    = 1;
    localparam int unsigned REQ_ADDR_BITS  = DBITS;
    localparam int unsigned REQ_WDATA_BITS = DBITS;

    typedef enum logic {
        CpuPri   = 1'b0,
        AuxForce = 1'b1
    } arb_state_e;

    typedef struct packed {
        logic                      req;
        logic [REQ_WE_BITS-1:0]    we;
        logic [REQ_ADDR_BITS-1:0]  addr;
        logic [REQ_WDATA_BITS-1:0] wdata;
    } req_bundle_t;

endpackage

// File: rtl/arb_starve_ctr.sv
// Bounded-starvation tracker: counts consecutive aux denials and raises
// force_aux for exactly one cycle once aux has waited MAXWAIT cycles.
module arb_starve_ctr
    import dmem_port_arbiter_pkg::*;
#(
    parameter int unsigned MAXWAIT = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic aux_req,
    input  logic aux_gnt,
    output logic force_aux
);

    localparam int unsigned WcntW = $clog2(MAXWAIT + 1);

    arb_state_e       state_q, state_d;
    logic [WcntW-1:0] wcnt_q, wcnt_d;

    // State and wait-counter registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= CpuPri;
            wcnt_q  <= '0;
        end else begin
            state_q <= state_d;
            wcnt_q  <= wcnt_d;
        end
    end

    // Next state: AuxForce always lasts one cycle, so CpuPri is the default
    always_comb begin
        state_d = CpuPri;
        wcnt_d  = wcnt_q;
        if (!aux_req || aux_gnt) begin
            wcnt_d = '0;
        end else if (state_q == CpuPri && wcnt_q != WcntW'(MAXWAIT)) begin
            wcnt_d = wcnt_q + WcntW'(1);
        end
        if (state_q == CpuPri && aux_req && !aux_gnt && wcnt_q == WcntW'(MAXWAIT - 1)) begin
            state_d = AuxForce;
        end
    end

    assign force_aux = (state_q == AuxForce);

endmodule

// File: rtl/dmem_port_arbiter.sv
// Shares the single-port dmem between the CPU MEM stage and an auxiliary
// master. CPU wins by default; aux is force-granted after MAXWAIT denials.
module dmem_port_arbiter
    import dmem_port_arbiter_pkg::*;
#(
    parameter int unsigned MAXWAIT = 4
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                cpu_req,
    input  logic                cpu_we,
    input  logic [DBITS-1:0]    cpu_addr,
    input  logic [DBITS-1:0]    cpu_wdata,
    output logic                cpu_gnt,
    output logic                cpu_stall,
    output logic                cpu_rvalid,
    output logic [DBITS-1:0]    cpu_rdata,
    input  logic                aux_req,
    input  logic                aux_we,
    input  logic [DBITS-1:0]    aux_addr,
    input  logic [DBITS-1:0]    aux_wdata,
    output logic                aux_gnt,
    output logic                aux_rvalid,
    output logic [DBITS-1:0]    aux_rdata,
    output logic                mem_en,
    output logic                mem_we,
    output logic [WIDXBITS-1:0] mem_addr,
    output logic [DBITS-1:0]    mem_wdata,
    input  logic [DBITS-1:0]    mem_rdata
);

    logic force_aux;
    logic rd_own_cpu_q;
    logic rd_own_aux_q;
    logic addr_unused;

    // Only the dmem byte-address window is decoded; the rest is ignored
    assign addr_unused = ^{cpu_addr[DBITS-1:DMEMADDRBITS], cpu_addr[DMEMWORDBITS-1:0],
                           aux_addr[DBITS-1:DMEMADDRBITS], aux_addr[DMEMWORDBITS-1:0]};

    arb_starve_ctr #(
        .MAXWAIT (MAXWAIT)
    ) u_starve (
        .clk       (clk),
        .reset     (reset),
        .aux_req   (aux_req),
        .aux_gnt   (aux_gnt),
        .force_aux (force_aux)
    );

    // Grant selection; everything is held low while reset is asserted
    always_comb begin
        cpu_gnt = 1'b0;
        aux_gnt = 1'b0;
        if (!reset) begin
            if (force_aux) begin
                aux_gnt = aux_req;
                cpu_gnt = cpu_req & ~aux_req;
            end else begin
                cpu_gnt = cpu_req;
                aux_gnt = aux_req & ~cpu_req;
            end
        end
        cpu_stall = cpu_req & ~cpu_gnt & ~reset;
    end

    // Drive the dmem port from whichever master holds the grant
    always_comb begin
        mem_en    = cpu_gnt | aux_gnt;
        mem_we    = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        if (cpu_gnt) begin
            mem_we    = cpu_we;
            mem_addr  = cpu_addr[DMEMADDRBITS-1:DMEMWORDBITS];
            mem_wdata = cpu_wdata;
        end else if (aux_gnt) begin
            mem_we    = aux_we;
            mem_addr  = aux_addr[DMEMADDRBITS-1:DMEMWORDBITS];
            mem_wdata = aux_wdata;
        end
    end

    // Tag the owner of a read so the returning data goes to one master only
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rd_own_cpu_q <= 1'b0;
            rd_own_aux_q <= 1'b0;
        end else begin
            rd_own_cpu_q <= cpu_gnt & ~cpu_we;
            rd_own_aux_q <= aux_gnt & ~aux_we;
        end
    end

    assign cpu_rvalid = rd_own_cpu_q;
    assign aux_rvalid = rd_own_aux_q;
    assign cpu_rdata  = rd_own_cpu_q ? mem_rdata : '0;
    assign aux_rdata  = rd_own_aux_q ? mem_rdata : '0;

endmodule
